seg7_scan_2digit: RTL and testbench
===================================

// Module: seg7_scan_2digit
// PURPOSE
//  Downstream display stage for the 2-digit BCD counter: time-multiplexes its num1:num0 outputs onto a
//  common-segment 2-digit 7-segment display. Holds a per-digit refresh prescaler and a 4-state scan FSM
//  with anti-ghosting blank gaps. Decodes BCD to segments, lights the digit-0 DP on max, blanks a leading zero.
// PARAMETERS
//  SCAN_DIV          1000  clocks each digit is lit per frame (>=1)
//  BLANK_CYCLES      2     clocks all digits are off before each digit slot (>=0; 0 = no blank states)
//  BLANK_LZ          1     1: digit1 dark when num1==0; 0: show '0'
//  SEG_ACTIVE_LOW    1     1: seg/dp drive 0 = lit
//  DIGIT_ACTIVE_LOW  1     1: an drives 0 = digit enabled
// PORTS
//  clk    in   1  single clock; all state on rising edge
//  rst    in   1  synchronous reset, active-high
//  num0   in   4  BCD units digit
//  num1   in   4  BCD tens digit
//  max    in   1  counter at terminal value (99)
//  seg    out  7  segments, seg[0]=a .. seg[6]=g
//  dp     out  1  decimal point
//  an     out  2  digit enables, an[0]=units, an[1]=tens
//  frame  out  1  1-cycle pulse on last cycle of each full refresh frame
// BEHAVIOUR
//  - Reset (rst high at edge): state=S_BLANK0, cnt=0, snapshots=0; an, seg, dp at inactive level; frame=0.
//    Mid-operation reset aborts any slot; outputs inactive from the following cycle.
//  - FSM S_BLANK0 -> S_DIG0 -> S_BLANK1 -> S_DIG1 -> S_BLANK0.
//    Each S_BLANKx lasts BLANK_CYCLES clocks; each S_DIGx lasts SCAN_DIV clocks.
//    If BLANK_CYCLES==0, blank states are skipped (S_DIG0 <-> S_DIG1).
//    Frame = 2*(SCAN_DIV+BLANK_CYCLES) clocks. cnt is $clog2-sized, clears on every state change.
//  - Snapshot: num0/max captured on the edge entering S_DIG0; num1 captured on the edge entering S_DIG1.
//    Input changes inside a slot are not shown until that digit's next slot entry.
//    Worst-case latency: one frame + 1 clock.
//  - Outputs are registers updated on the same edge as the state register; no combinational input->output path.
//  - S_BLANKx: all an inactive, seg and dp inactive.
//  - S_DIG0: an[0] active; seg=decode(num0 snap); dp lit iff max snap==1.
//  - S_DIG1: an[1] active unless BLANK_LZ && num1 snap==0 (then an all inactive); seg=decode(num1 snap); dp unlit.
//  - Decode (active-high, {g..a}): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
//    Codes 10-15 show '-' (40). SEG_ACTIVE_LOW inverts seg and dp; DIGIT_ACTIVE_LOW inverts an.
//  - frame is high only in the final clock of S_DIG1 (cnt==SCAN_DIV-1), regardless of blanking.
//  - Never two an bits active in the same cycle.
// TESTING (SCAN_DIV=4, BLANK_CYCLES=1, all active-low unless noted)
//  1. rst high 3 clks, then low -> during reset and first cycle after: an=11, seg=7F, dp=1, frame=0.
//  2. num1=4, num0=2 steady -> repeating 10-clk frame: an=11 x1, an=10 seg=24 x4, an=11 x1, an=01 seg=19 x4.
//     frame=1 on the last an=01 cycle only.
//  3. num1=0, num0=7 -> digit1 slot has an=11 (blanked); units seg=78.
//     Same stimulus with BLANK_LZ=0 -> digit1 slot has an=01, seg=40.
//  4. num1=9, num0=9, max=1 -> dp=0 only in the digit0 slot; seg=10 in both slots; dp=1 elsewhere.
//  5. num0=4'hC -> seg=3F ('-') in the digit0 slot.
//     BLANK_CYCLES=0 -> 8-clk frame; an alternates 10/01 with no 11 gap.
//  6. num0 changes 2->3 at 2nd clk of S_DIG0 -> seg stays 24 for rest of slot, shows 30 next frame.
//     rst pulse mid-S_DIG1 -> next cycle an=11; scan restarts at S_BLANK0.

Source files
------------

// File: rtl/seg7_scan_2digit.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_2digit
//  Description : Two-digit multiplexed 7-segment driver for a BCD counter.
//                Scans units then tens with all-off gaps between digits.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_scan_2digit #(
    parameter int SCAN_DIV         = 1000,
    parameter int BLANK_CYCLES     = 2,
    parameter bit BLANK_LZ         = 1'b1,
    parameter bit SEG_ACTIVE_LOW   = 1'b1,
    parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] num0,
    input  logic [3:0] num1,
    input  logic       max,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] an,
    output logic       frame
);

    // One counter serves both slot kinds, so it is sized for the longer one.
    localparam int c_CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_DIG_LAST   = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK_LAST =
        c_CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam bit c_NO_BLANK = (BLANK_CYCLES == 0);

    localparam logic [6:0] c_SEG_OFF = SEG_ACTIVE_LOW   ? 7'h7F : 7'h00;
    localparam logic       c_DP_OFF  = SEG_ACTIVE_LOW   ? 1'b1  : 1'b0;
    localparam logic [1:0] c_AN_OFF  = DIGIT_ACTIVE_LOW ? 2'b11 : 2'b00;

    typedef enum logic [1:0] {
        S_BLANK0 = 2'd0,
        S_DIG0   = 2'd1,
        S_BLANK1 = 2'd2,
        S_DIG1   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               w_slot_done;

    logic [3:0]         r_snap0;
    logic [3:0]         r_snap1;
    logic               r_snap_max;
    logic [3:0]         w_snap0_next;
    logic [3:0]         w_snap1_next;
    logic               w_snap_max_next;

    logic [6:0]         r_seg;
    logic               r_dp;
    logic [1:0]         r_an;
    logic               r_frame;

    logic [6:0]         w_seg_on;
    logic               w_dp_on;
    logic [1:0]         w_an_on;
    logic [6:0]         w_seg_next;
    logic               w_dp_next;
    logic [1:0]         w_an_next;
    logic               w_frame_next;

    // Active-high segment pattern, bit 0 = a .. bit 6 = g.
    function automatic logic [6:0] f_decode(input logic [3:0] bcd);
        logic [6:0] v_seg;
        case (bcd)
            4'd0:    v_seg = 7'h3F;
            4'd1:    v_seg = 7'h06;
            4'd2:    v_seg = 7'h5B;
            4'd3:    v_seg = 7'h4F;
            4'd4:    v_seg = 7'h66;
            4'd5:    v_seg = 7'h6D;
            4'd6:    v_seg = 7'h7D;
            4'd7:    v_seg = 7'h07;
            4'd8:    v_seg = 7'h7F;
            4'd9:    v_seg = 7'h6F;
            default: v_seg = 7'h40;
        endcase
        return v_seg;
    endfunction

    always_comb begin
        w_slot_done  = 1'b0;
        w_state_next = r_state;
        case (r_state)
            S_BLANK0, S_BLANK1: w_slot_done = c_NO_BLANK || (r_cnt == c_BLANK_LAST);
            S_DIG0, S_DIG1:     w_slot_done = (r_cnt == c_DIG_LAST);
            default:            w_slot_done = 1'b1;
        endcase

        if (w_slot_done) begin
            case (r_state)
                S_BLANK0: w_state_next = S_DIG0;
                S_DIG0:   w_state_next = c_NO_BLANK ? S_DIG1 : S_BLANK1;
                S_BLANK1: w_state_next = S_DIG1;
                S_DIG1:   w_state_next = c_NO_BLANK ? S_DIG0 : S_BLANK0;
                default:  w_state_next = S_BLANK0;
            endcase
        end

        w_cnt_next = w_slot_done ? '0 : r_cnt + 1'b1;
    end

    // Snapshots are taken only on slot entry so a digit never changes mid-slot.
    always_comb begin
        w_snap0_next    = r_snap0;
        w_snap_max_next = r_snap_max;
        w_snap1_next    = r_snap1;
        if ((w_state_next == S_DIG0) && (r_state != S_DIG0)) begin
            w_snap0_next    = num0;
            w_snap_max_next = max;
        end
        if ((w_state_next == S_DIG1) && (r_state != S_DIG1)) begin
            w_snap1_next = num1;
        end
    end

    // Outputs are computed for the upcoming state so they register alongside it.
    always_comb begin
        w_seg_on     = 7'h00;
        w_dp_on      = 1'b0;
        w_an_on      = 2'b00;
        w_frame_next = 1'b0;
        case (w_state_next)
            S_DIG0: begin
                w_an_on  = 2'b01;
                w_seg_on = f_decode(w_snap0_next);
                w_dp_on  = w_snap_max_next;
            end
            S_DIG1: begin
                w_an_on      = (BLANK_LZ && (w_snap1_next == 4'd0)) ? 2'b00 : 2'b10;
                w_seg_on     = f_decode(w_snap1_next);
                w_frame_next = (w_cnt_next == c_DIG_LAST);
            end
            default: begin
                w_an_on  = 2'b00;
                w_seg_on = 7'h00;
            end
        endcase

        w_seg_next = SEG_ACTIVE_LOW   ? ~w_seg_on : w_seg_on;
        w_dp_next  = SEG_ACTIVE_LOW   ? ~w_dp_on  : w_dp_on;
        w_an_next  = DIGIT_ACTIVE_LOW ? ~w_an_on  : w_an_on;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_BLANK0;
            r_cnt      <= '0;
            r_snap0    <= 4'd0;
            r_snap1    <= 4'd0;
            r_snap_max <= 1'b0;
            r_seg      <= c_SEG_OFF;
            r_dp       <= c_DP_OFF;
            r_an       <= c_AN_OFF;
            r_frame    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_snap0    <= w_snap0_next;
            r_snap1    <= w_snap1_next;
            r_snap_max <= w_snap_max_next;
            r_seg      <= w_seg_next;
            r_dp       <= w_dp_next;
            r_an       <= w_an_next;
            r_frame    <= w_frame_next;
        end
    end

    assign seg   = r_seg;
    assign dp    = r_dp;
    assign an    = r_an;
    assign frame = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_2digit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_2digit
//  Description : Randomised bench comparing three display configurations
//                against a frame-position reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_scan_2digit;

    localparam int c_D = 4;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [3:0] num0 = 4'd0;
    logic [3:0] num1 = 4'd0;
    logic       max  = 1'b0;

    logic [6:0] o_seg   [3];
    logic       o_dp    [3];
    logic [1:0] o_an    [3];
    logic       o_frame [3];

    always #5 clk = ~clk;

    seg7_scan_2digit #(.SCAN_DIV(c_D), .BLANK_CYCLES(1), .BLANK_LZ(1'b1),
                       .SEG_ACTIVE_LOW(1'b1), .DIGIT_ACTIVE_LOW(1'b1)) u_dut (
        .clk(clk), .rst(rst), .num0(num0), .num1(num1), .max(max),
        .seg(o_seg[0]), .dp(o_dp[0]), .an(o_an[0]), .frame(o_frame[0]));

    seg7_scan_2digit #(.SCAN_DIV(c_D), .BLANK_CYCLES(1), .BLANK_LZ(1'b0),
                       .SEG_ACTIVE_LOW(1'b1), .DIGIT_ACTIVE_LOW(1'b1)) u_dut_nlz (
        .clk(clk), .rst(rst), .num0(num0), .num1(num1), .max(max),
        .seg(o_seg[1]), .dp(o_dp[1]), .an(o_an[1]), .frame(o_frame[1]));

    seg7_scan_2digit #(.SCAN_DIV(c_D), .BLANK_CYCLES(0), .BLANK_LZ(1'b1),
                       .SEG_ACTIVE_LOW(1'b1), .DIGIT_ACTIVE_LOW(1'b1)) u_dut_nb (
        .clk(clk), .rst(rst), .num0(num0), .num1(num1), .max(max),
        .seg(o_seg[2]), .dp(o_dp[2]), .an(o_an[2]), .frame(o_frame[2]));

    int         cfg_b  [3] = '{1, 1, 0};
    int         cfg_lz [3] = '{1, 0, 1};

    int         m_k  [3];
    logic [3:0] m_s0 [3];
    logic [3:0] m_s1 [3];
    logic       m_mx [3];

    logic [1:0] e_an  [3];
    logic [6:0] e_seg [3];
    logic       e_dp  [3];
    logic       e_fr  [3];

    logic [6:0] dec_tab [16];

    int n_tests = 0;
    int n_fail  = 0;

    // Cycle k since reset -> 0 blank, 1 units slot, 2 tens slot.
    function automatic int slot_of(input int b, input int k);
        int f, p, q;
        if (b > 0) begin
            f = 2 * (c_D + b);
            p = k % f;
            if (p < b)             return 0;
            if (p < b + c_D)       return 1;
            if (p < 2 * b + c_D)   return 0;
            return 2;
        end
        if (k == 0) return 0;
        q = (k - 1) % (2 * c_D);
        return (q < c_D) ? 1 : 2;
    endfunction

    function automatic bit last_of(input int b, input int k);
        if (b > 0) return (k % (2 * (c_D + b))) == (2 * (c_D + b) - 1);
        if (k == 0) return 1'b0;
        return ((k - 1) % (2 * c_D)) == (2 * c_D - 1);
    endfunction

    task automatic tick();
        int so, sn;
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            if (rst) begin
                m_k[c]  = 0;
                m_s0[c] = 4'd0;
                m_s1[c] = 4'd0;
                m_mx[c] = 1'b0;
            end else begin
                so = slot_of(cfg_b[c], m_k[c]);
                m_k[c] = m_k[c] + 1;
                sn = slot_of(cfg_b[c], m_k[c]);
                if (sn == 1 && so != 1) begin
                    m_s0[c] = num0;
                    m_mx[c] = max;
                end
                if (sn == 2 && so != 2) m_s1[c] = num1;
            end
            sn       = slot_of(cfg_b[c], m_k[c]);
            e_an[c]  = 2'b11;
            e_seg[c] = 7'h7F;
            e_dp[c]  = 1'b1;
            e_fr[c]  = 1'b0;
            if (sn == 1) begin
                e_an[c]  = 2'b10;
                e_seg[c] = ~dec_tab[m_s0[c]];
                e_dp[c]  = ~m_mx[c];
            end else if (sn == 2) begin
                e_an[c]  = (cfg_lz[c] != 0 && m_s1[c] == 4'd0) ? 2'b11 : 2'b01;
                e_seg[c] = ~dec_tab[m_s1[c]];
                e_fr[c]  = last_of(cfg_b[c], m_k[c]);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            for (int c = 0; c < 3; c++) begin
                n_tests++;
                if ({o_an[c], o_seg[c], o_dp[c], o_frame[c]} !== {2'b11, 7'h7F, 1'b1, 1'b0}) begin
                    n_fail++;
                    $display("FAIL reset cfg%0d: got an=%b seg=%h dp=%b frame=%b, expected an=11 seg=7f dp=1 frame=0",
                             c, o_an[c], o_seg[c], o_dp[c], o_frame[c]);
                end
            end
        end
        rst = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if ({o_an[c], o_seg[c], o_dp[c], o_frame[c]} !== {2'b11, 7'h7F, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL post_reset cfg%0d: got an=%b seg=%h dp=%b frame=%b, expected an=11 seg=7f dp=1 frame=0",
                         c, o_an[c], o_seg[c], o_dp[c], o_frame[c]);
            end
        end
    endtask

    task automatic test_pattern(input string name, input logic [3:0] n1, input logic [3:0] n0,
                                input logic mx, input logic [6:0] lit0, input logic [6:0] lit1);
        num1 = n1;
        num0 = n0;
        max  = mx;
        for (int i = 0; i < 30; i++) begin
            tick();
            for (int c = 0; c < 3; c++) begin
                n_tests++;
                if ({o_an[c], o_seg[c], o_dp[c], o_frame[c]} !== {e_an[c], e_seg[c], e_dp[c], e_fr[c]}) begin
                    n_fail++;
                    $display("FAIL %s cfg%0d k=%0d: got an=%b seg=%h dp=%b frame=%b, expected an=%b seg=%h dp=%b frame=%b",
                             name, c, m_k[c], o_an[c], o_seg[c], o_dp[c], o_frame[c],
                             e_an[c], e_seg[c], e_dp[c], e_fr[c]);
                end
            end
            // Fixed anchors for the blanking configuration once both slots hold this pattern.
            if (i >= 12 && slot_of(1, m_k[0]) == 1) begin
                n_tests++;
                if (o_seg[0] !== lit0) begin
                    n_fail++;
                    $display("FAIL %s_units_seg: got %h, expected %h", name, o_seg[0], lit0);
                end
            end
            if (i >= 12 && slot_of(1, m_k[1]) == 2) begin
                n_tests++;
                if (o_seg[1] !== lit1) begin
                    n_fail++;
                    $display("FAIL %s_tens_seg: got %h, expected %h", name, o_seg[1], lit1);
                end
            end
        end
    endtask

    task automatic test_midslot_change();
        int guard;
        num1 = 4'd4;
        num0 = 4'd2;
        max  = 1'b0;
        guard = 0;
        while (slot_of(1, m_k[0]) != 0 && guard < 20) begin tick(); guard++; end
        while (slot_of(1, m_k[0]) != 1 && guard < 20) begin tick(); guard++; end
        n_tests++;
        if (guard >= 20 || o_an[0] !== 2'b10) begin
            n_fail++;
            $display("FAIL midslot_sync: got an=%b after %0d clks, expected an=10", o_an[0], guard);
        end
        num0 = 4'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (o_seg[0] !== 7'h24) begin
                n_fail++;
                $display("FAIL midslot_hold: got seg=%h, expected 24", o_seg[0]);
            end
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            for (int c = 0; c < 3; c++) begin
                n_tests++;
                if ({o_an[c], o_seg[c], o_dp[c], o_frame[c]} !== {e_an[c], e_seg[c], e_dp[c], e_fr[c]}) begin
                    n_fail++;
                    $display("FAIL midslot_next cfg%0d: got an=%b seg=%h, expected an=%b seg=%h",
                             c, o_an[c], o_seg[c], e_an[c], e_seg[c]);
                end
            end
            if (slot_of(1, m_k[0]) == 1) begin
                n_tests++;
                if (o_seg[0] !== 7'h30) begin
                    n_fail++;
                    $display("FAIL midslot_update: got seg=%h, expected 30", o_seg[0]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int guard;
        num1 = 4'd5;
        num0 = 4'd6;
        guard = 0;
        while (slot_of(1, m_k[0]) != 2 && guard < 20) begin tick(); guard++; end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (o_an[c] !== 2'b11 || o_seg[c] !== 7'h7F || o_frame[c] !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset cfg%0d: got an=%b seg=%h frame=%b, expected an=11 seg=7f frame=0",
                         c, o_an[c], o_seg[c], o_frame[c]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            for (int c = 0; c < 3; c++) begin
                n_tests++;
                if ({o_an[c], o_seg[c], o_dp[c], o_frame[c]} !== {e_an[c], e_seg[c], e_dp[c], e_fr[c]}) begin
                    n_fail++;
                    $display("FAIL restart cfg%0d k=%0d: got an=%b seg=%h frame=%b, expected an=%b seg=%h frame=%b",
                             c, m_k[c], o_an[c], o_seg[c], o_frame[c], e_an[c], e_seg[c], e_fr[c]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                num0 = 4'($urandom_range(0, 15));
                num1 = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                max  = 1'($urandom_range(0, 1));
            end
            rst = ($urandom_range(0, 63) == 0);
            tick();
            for (int c = 0; c < 3; c++) begin
                n_tests++;
                if ({o_an[c], o_seg[c], o_dp[c], o_frame[c]} !== {e_an[c], e_seg[c], e_dp[c], e_fr[c]}) begin
                    n_fail++;
                    $display("FAIL random cfg%0d k=%0d: got an=%b seg=%h dp=%b frame=%b, expected an=%b seg=%h dp=%b frame=%b",
                             c, m_k[c], o_an[c], o_seg[c], o_dp[c], o_frame[c],
                             e_an[c], e_seg[c], e_dp[c], e_fr[c]);
                end
                n_tests++;
                if (o_an[c] === 2'b00) begin
                    n_fail++;
                    $display("FAIL random_two_digits cfg%0d: got an=%b, expected at most one active", c, o_an[c]);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        dec_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        for (int c = 0; c < 3; c++) begin
            m_k[c]  = 0;
            m_s0[c] = 4'd0;
            m_s1[c] = 4'd0;
            m_mx[c] = 1'b0;
        end
        test_reset();
        test_pattern("steady",   4'd4, 4'd2,  1'b0, 7'h24, 7'h19);
        test_pattern("lead_zero", 4'd0, 4'd7, 1'b0, 7'h78, 7'h40);
        test_pattern("max_dp",   4'd9, 4'd9,  1'b1, 7'h10, 7'h10);
        test_pattern("invalid",  4'd3, 4'hC,  1'b0, 7'h3F, 7'h30);
        test_midslot_change();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
